// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl shared definitions: word size, FSM encodings,
// requester source codes and a small state helper.
package mem_bus_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [2:0] MB_IDLE    = 3'd0;
  localparam logic [2:0] MB_RD_WAIT = 3'd1;
  localparam logic [2:0] MB_RD_REL  = 3'd2;
  localparam logic [2:0] MB_WR_WAIT = 3'd3;
  localparam logic [2:0] MB_WR_REL  = 3'd4;

  localparam logic MB_SRC_FETCH = 1'b0;
  localparam logic MB_SRC_DATA  = 1'b1;

  function automatic logic mb_busy(
    input logic [2:0] s
  );
    return s != MB_IDLE;
  endfunction

endpackage

// File: rtl/mb_timeout_ctr.sv
// Handshake watchdog: clear, enable, terminal count.
// tc is high while enabled on the TIMEOUT-th cycle since clear.
module mb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !tc) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared memory bus sequencer: fetch + load/store requesters,
// readM/writeM strobes, 4-phase inputReady/ackOutput, watchdog.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WORD_W  = WORD_SIZE,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_valid,
  output logic [WORD_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_done,
  output logic [WORD_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              busy,
  output logic              readM,
  output logic              writeM,
  output logic [WORD_W-1:0] address,
  inout  wire  [WORD_W-1:0] data,
  input  logic              inputReady,
  input  logic              ackOutput
);

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic              src;
  logic              drive_en;
  logic [WORD_W-1:0] wdata_q;
  logic              tmr_clr;
  logic              tc;

  assign data = drive_en ? wdata_q : 'z;
  assign busy = mb_busy(state);

  // timer restarts on every state change
  assign tmr_clr = (nxt != state);

  mb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .enable  (busy),
    .tc      (tc)
  );

  // a response arriving on the last cycle still wins over tc
  always_comb begin
    nxt = state;
    case (state)
      MB_IDLE: begin
        if (d_req)
          nxt = d_we ? MB_WR_WAIT : MB_RD_WAIT;
        else if (if_req)
          nxt = MB_RD_WAIT;
      end
      MB_RD_WAIT: begin
        if (inputReady)
          nxt = MB_RD_REL;
        else if (tc)
          nxt = MB_IDLE;
      end
      MB_RD_REL: begin
        if (!inputReady || tc)
          nxt = MB_IDLE;
      end
      MB_WR_WAIT: begin
        if (ackOutput)
          nxt = MB_WR_REL;
        else if (tc)
          nxt = MB_IDLE;
      end
      MB_WR_REL: begin
        if (!ackOutput || tc)
          nxt = MB_IDLE;
      end
      default: nxt = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= MB_IDLE;
      src      <= MB_SRC_FETCH;
      readM    <= 1'b0;
      writeM   <= 1'b0;
      drive_en <= 1'b0;
      wdata_q  <= '0;
      address  <= '0;
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      bus_err  <= 1'b0;
      if_data  <= '0;
      d_rdata  <= '0;
    end else begin
      state    <= nxt;
      if_valid <= 1'b0;
      d_done   <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        MB_IDLE: begin
          if (d_req) begin
            address <= d_addr;
            src     <= MB_SRC_DATA;
            if (d_we) begin
              wdata_q  <= d_wdata;
              drive_en <= 1'b1;
              writeM   <= 1'b1;
            end else begin
              readM <= 1'b1;
            end
          end else if (if_req) begin
            address <= if_addr;
            src     <= MB_SRC_FETCH;
            readM   <= 1'b1;
          end
        end
        MB_RD_WAIT: begin
          if (inputReady) begin
            readM <= 1'b0;
            if (src == MB_SRC_FETCH) begin
              if_data  <= data;
              if_valid <= 1'b1;
            end else begin
              d_rdata <= data;
              d_done  <= 1'b1;
            end
          end else if (tc) begin
            readM   <= 1'b0;
            bus_err <= 1'b1;
            if (src == MB_SRC_FETCH)
              if_valid <= 1'b1;
            else
              d_done <= 1'b1;
          end
        end
        // owner was already told; only flag the stuck release
        MB_RD_REL: begin
          if (inputReady && tc)
            bus_err <= 1'b1;
        end
        MB_WR_WAIT: begin
          if (ackOutput) begin
            writeM   <= 1'b0;
            drive_en <= 1'b0;
            d_done   <= 1'b1;
          end else if (tc) begin
            writeM   <= 1'b0;
            drive_en <= 1'b0;
            d_done   <= 1'b1;
            bus_err  <= 1'b1;
          end
        end
        MB_WR_REL: begin
          if (ackOutput && tc)
            bus_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: vector table of single
// transactions plus arbitration, timeout and reset sequences.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_valid;
  logic [W-1:0] if_data;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic         d_done;
  logic [W-1:0] d_rdata;
  logic         bus_err;
  logic         busy;
  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  wire  [W-1:0] data;
  logic         inputReady = 1'b0;
  logic         ackOutput = 1'b0;

  logic         mem_oe = 1'b0;
  logic [W-1:0] mem_q = '0;

  assign data = mem_oe ? mem_q : 'z;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .WORD_W  (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_valid   (if_valid),
    .if_data    (if_data),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .bus_err    (bus_err),
    .busy       (busy),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput)
  );

  int n_ifv = 0;
  int n_dd  = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (if_valid) n_ifv <= n_ifv + 1;
    if (d_done)   n_dd  <= n_dd + 1;
    if (bus_err)  n_err <= n_err + 1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // undriven bus reads as z (4-state) or 0 (2-state)
  task automatic chk_z(input string name);
    n_chk++;
    if (data != '0) begin
      n_fail++;
      $display("FAIL %s: bus %h expected z", name, data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 fetch, 1 load, 2 store
  typedef struct {
    int           kind;
    logic [W-1:0] addr;
    logic [W-1:0] val;
    int           lat;
    logic [W-1:0] exp_ifd;
    logic [W-1:0] exp_drd;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v, input string tag);
    int  i0;
    int  d0;
    logic st;
    i0 = n_ifv;
    d0 = n_dd;
    if (v.kind == 0) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_we    = (v.kind == 2);
      d_addr  = v.addr;
      d_wdata = v.val;
    end
    tick();
    chk({tag, ".addr"}, address, v.addr);
    for (int i = 0; i <= v.lat; i++) begin
      if (i > 0) tick();
      st = (v.kind == 2) ? writeM : readM;
      chk({tag, ".strobe"}, 16'(st), 16'd1);
      if (v.kind == 2)
        chk({tag, ".wdata"}, data, v.val);
    end
    if (v.kind == 2) begin
      ackOutput = 1'b1;
    end else begin
      inputReady = 1'b1;
      mem_oe     = 1'b1;
      mem_q      = v.val;
    end
    tick();
    chk({tag, ".strobe_off"}, 16'(readM | writeM), 16'd0);
    chk({tag, ".ifv"}, 16'(if_valid), 16'(v.kind == 0));
    chk({tag, ".ddone"}, 16'(d_done), 16'(v.kind != 0));
    chk({tag, ".if_data"}, if_data, v.exp_ifd);
    chk({tag, ".d_rdata"}, d_rdata, v.exp_drd);
    chk({tag, ".busy_rel"}, 16'(busy), 16'd1);
    if (v.kind == 2) begin
      mem_oe = 1'b0;
      chk_z({tag, ".z_after_ack"});
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    chk({tag, ".pulse_once"}, 16'(if_valid | d_done), 16'd0);
    chk({tag, ".busy_hold"}, 16'(busy), 16'd1);
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_oe     = 1'b0;
    tick();
    chk({tag, ".busy_end"}, 16'(busy), 16'd0);
    chk({tag, ".addr_hold"}, address, v.addr);
    chk({tag, ".n_ifv"}, 16'(n_ifv - i0), 16'(v.kind == 0));
    chk({tag, ".n_dd"}, 16'(n_dd - d0), 16'(v.kind != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0;
    int d0;
    int e0;
    int n;
    vec_t fv;

    vecs[0] = '{0, 16'h0010, 16'h6A05, 2, 16'h6A05, 16'h0000};
    vecs[1] = '{1, 16'h0042, 16'hBEEF, 1, 16'h6A05, 16'hBEEF};
    vecs[2] = '{2, 16'h0033, 16'h1234, 3, 16'h6A05, 16'hBEEF};
    vecs[3] = '{0, 16'hFFFF, 16'h0001, 0, 16'h0001, 16'hBEEF};
    vecs[4] = '{1, 16'h0000, 16'hFFFF, 4, 16'h0001, 16'hFFFF};
    vecs[5] = '{2, 16'hFFFE, 16'hA5A5, 0, 16'h0001, 16'hFFFF};

    #2;
    chk("rst.readM", 16'(readM), 16'd0);
    chk("rst.writeM", 16'(writeM), 16'd0);
    chk("rst.addr", address, 16'h0000);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.pulses", 16'(if_valid | d_done | bus_err), 16'd0);
    chk("rst.if_data", if_data, 16'h0000);
    chk("rst.d_rdata", d_rdata, 16'h0000);
    chk_z("rst.data");
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // handshake inputs in IDLE must be ignored
    inputReady = 1'b1;
    ackOutput  = 1'b1;
    mem_oe     = 1'b1;
    mem_q      = 16'hDEAD;
    tick();
    tick();
    chk("idle_ign.busy", 16'(busy), 16'd0);
    chk("idle_ign.strobe", 16'(readM | writeM), 16'd0);
    chk("idle_ign.if_data", if_data, 16'h0000);
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_oe     = 1'b0;
    tick();

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i], $sformatf("v%0d", i));

    // simultaneous load + fetch: load first, then fetch
    i0 = n_ifv;
    d0 = n_dd;
    if_req  = 1'b1;
    if_addr = 16'h0020;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0050;
    tick();
    chk("sim.first_addr", address, 16'h0050);
    chk("sim.first_rd", 16'(readM), 16'd1);
    inputReady = 1'b1;
    mem_oe     = 1'b1;
    mem_q      = 16'h1111;
    tick();
    chk("sim.ddone", 16'(d_done), 16'd1);
    chk("sim.no_ifv", 16'(if_valid), 16'd0);
    chk("sim.d_rdata", d_rdata, 16'h1111);
    d_req      = 1'b0;
    inputReady = 1'b0;
    mem_oe     = 1'b0;
    tick();
    chk("sim.idle_gap", 16'(busy), 16'd0);
    tick();
    chk("sim.fetch_addr", address, 16'h0020);
    chk("sim.fetch_rd", 16'(readM), 16'd1);
    inputReady = 1'b1;
    mem_oe     = 1'b1;
    mem_q      = 16'h2222;
    tick();
    chk("sim.ifv", 16'(if_valid), 16'd1);
    chk("sim.if_data", if_data, 16'h2222);
    if_req     = 1'b0;
    inputReady = 1'b0;
    mem_oe     = 1'b0;
    tick();
    tick();
    chk("sim.n_ifv", 16'(n_ifv - i0), 16'd1);
    chk("sim.n_dd", 16'(n_dd - d0), 16'd1);
    chk("sim.busy_end", 16'(busy), 16'd0);

    // read timeout with a silent memory
    i0 = n_ifv;
    e0 = n_err;
    if_req  = 1'b1;
    if_addr = 16'h0077;
    tick();
    n = 0;
    while (readM && n < 4 * TMO) begin
      n++;
      tick();
    end
    chk("tmo.rd_cycles", 16'(n), 16'(TMO));
    chk("tmo.bus_err", 16'(bus_err), 16'd1);
    chk("tmo.ifv", 16'(if_valid), 16'd1);
    chk("tmo.busy", 16'(busy), 16'd0);
    chk("tmo.if_data", if_data, 16'h2222);
    chk("tmo.d_rdata", d_rdata, 16'h1111);
    if_req = 1'b0;
    tick();
    tick();
    chk("tmo.n_err", 16'(n_err - e0), 16'd1);
    chk("tmo.n_ifv", 16'(n_ifv - i0), 16'd1);

    // async reset in the middle of a store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0099;
    d_wdata = 16'h5555;
    tick();
    chk("rstw.writeM_on", 16'(writeM), 16'd1);
    chk("rstw.data_on", data, 16'h5555);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw.writeM", 16'(writeM), 16'd0);
    chk("rstw.busy", 16'(busy), 16'd0);
    chk("rstw.addr", address, 16'h0000);
    chk("rstw.if_data", if_data, 16'h0000);
    chk_z("rstw.data");
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    fv = '{0, 16'h0100, 16'hC0DE, 1, 16'hC0DE, 16'h0000};
    run_txn(fv, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
